// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control block: FSM state encoding and
// default timing parameters, also used by the datapath and the bench.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_LAP    = 2'b11
  } sw_state_e;

  localparam int unsigned DEF_CLK_PER_TICK    = 5_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button and datapath-facing signals of the stopwatch controller.
// The controller uses the master view; the datapath/board side uses the slave view.
interface stopwatch_ctrl_if;
  import stopwatch_ctrl_pkg::*;

  logic      start_resume;
  logic      stop;
  logic      lap;
  logic      at_max;
  logic      cnt_en;
  logic      cnt_clr;
  logic      disp_freeze;
  sw_state_e state;

  modport master (
    input  start_resume, stop, lap, at_max,
    output cnt_en, cnt_clr, disp_freeze, state
  );

  modport slave (
    output start_resume, stop, lap, at_max,
    input  cnt_en, cnt_clr, disp_freeze, state
  );

endinterface

// File: rtl/stopwatch_ctrl_debounce.sv
// One push-button conditioner: 2-FF synchroniser, stable-level debouncer and a
// single-cycle strobe on the rising edge of the accepted level.
module stopwatch_ctrl_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          level_dly_q, level_dly_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only survives while every cycle disagrees with the accepted level,
  // so a glitch shorter than DEBOUNCE_CYCLES never flips the level.
  always_comb begin
    sync1_d     = raw;
    sync2_d     = sync1_q;
    level_d     = level_q;
    cnt_d       = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    level_dly_d = level_q;
    press_d     = level_q & ~level_dly_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      press_q     <= press_d;
      cnt_q       <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing: debounced buttons drive the IDLE/RUN/PAUSED/LAP machine,
// and a prescaler turns clk into the 0.1 s count-enable strobe for the datapath.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned CLK_PER_TICK    = DEF_CLK_PER_TICK,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input logic             clk,
  input logic             reset,
  stopwatch_ctrl_if.master bus
);

  localparam int unsigned PW = $clog2(CLK_PER_TICK);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_TICK - 1);

  logic start_p, stop_p, lap_p;

  stopwatch_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk(clk), .reset(reset), .raw(bus.start_resume), .press(start_p));
  stopwatch_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_stop (
    .clk(clk), .reset(reset), .raw(bus.stop), .press(stop_p));
  stopwatch_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk(clk), .reset(reset), .raw(bus.lap), .press(lap_p));

  sw_state_e     state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          cnt_en_q, cnt_en_d;
  logic          cnt_clr_q, cnt_clr_d;
  logic          freeze_q, freeze_d;
  logic          running, tick;

  // Buttons and the tick are both judged against the current state, so a stop
  // arriving on a tick edge still lets that tick's increment through.
  always_comb begin
    running   = (state_q == ST_RUN) || (state_q == ST_LAP);
    tick      = running && (presc_q == PRESC_MAX);
    state_d   = state_q;
    cnt_clr_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (stop_p)       cnt_clr_d = 1'b1;
        else if (start_p) state_d   = ST_RUN;
      end
      ST_RUN: begin
        if (stop_p)      state_d = ST_PAUSED;
        else if (lap_p)  state_d = ST_LAP;
      end
      ST_LAP: begin
        if (stop_p)      state_d = ST_PAUSED;
        else if (lap_p)  state_d = ST_RUN;
      end
      ST_PAUSED: begin
        if (stop_p) begin
          state_d   = ST_IDLE;
          cnt_clr_d = 1'b1;
        end else if (start_p) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The datapath cannot go past 9:59.9, so a tick at the limit parks the watch.
    if (tick && bus.at_max) state_d = ST_PAUSED;

    cnt_en_d = tick && !bus.at_max;

    if (tick)         presc_d = '0;
    else if (running) presc_d = presc_q + 1'b1;
    else              presc_d = presc_q;
    if (state_d == ST_IDLE) presc_d = '0;

    freeze_d = (state_d == ST_LAP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b1;
      freeze_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      cnt_en_q  <= cnt_en_d;
      cnt_clr_q <= cnt_clr_d;
      freeze_q  <= freeze_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.cnt_en      = cnt_en_q;
  assign bus.cnt_clr     = cnt_clr_q;
  assign bus.disp_freeze = freeze_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a 10-cycle tick and 4-cycle debounce:
// a reset vector table followed by hand-written multi-cycle button sequences.
module tb_stopwatch_ctrl;
  import stopwatch_ctrl_pkg::*;

  localparam int TICK = 10;

  typedef struct {
    logic       rst;
    logic       start_resume;
    logic       stop;
    logic       lap;
    logic       at_max;
    logic [1:0] exp_state;
    logic       exp_en;
    logic       exp_clr;
    logic       exp_frz;
  } vec_t;

  logic clk;
  logic reset;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(.CLK_PER_TICK(TICK), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk),
    .reset(reset),
    .bus(sw_if)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int en_count = 0;
  int clr_count = 0;
  int last_en_cyc = -1;
  int first_en_cyc = -1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (sw_if.cnt_en === 1'b1) begin
      en_count++;
      last_en_cyc = cyc;
      if (first_en_cyc == -1) first_en_cyc = cyc;
    end
    if (sw_if.cnt_clr === 1'b1) clr_count++;
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset              = v.rst;
    sw_if.start_resume = v.start_resume;
    sw_if.stop         = v.stop;
    sw_if.lap          = v.lap;
    sw_if.at_max       = v.at_max;
    step();
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    checkValue($sformatf("vec%0d_state", idx), int'(sw_if.state), int'(v.exp_state));
    checkValue($sformatf("vec%0d_cnt_en", idx), int'(sw_if.cnt_en), int'(v.exp_en));
    checkValue($sformatf("vec%0d_cnt_clr", idx), int'(sw_if.cnt_clr), int'(v.exp_clr));
    checkValue($sformatf("vec%0d_freeze", idx), int'(sw_if.disp_freeze), int'(v.exp_frz));
  endtask

  // Holds the masked buttons {start,stop,lap} for 10 cycles; the state must still be
  // exp_before after the 7th edge and become exp_after on the 8th, then release settles.
  task automatic pressButton(input logic [2:0] mask, input logic [1:0] exp_before,
                             input logic [1:0] exp_after, input string name,
                             output int chg);
    chg = -1;
    sw_if.start_resume = mask[2];
    sw_if.stop         = mask[1];
    sw_if.lap          = mask[0];
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 7) checkValue({name, "_before"}, int'(sw_if.state), int'(exp_before));
      if (i == 8) begin
        checkValue({name, "_after"}, int'(sw_if.state), int'(exp_after));
        chg = cyc;
      end
    end
    sw_if.start_resume = 1'b0;
    sw_if.stop         = 1'b0;
    sw_if.lap          = 1'b0;
    repeat (7) step();
  endtask

  task automatic waitFirstEn(input string name, input int bound);
    int n;
    n = 0;
    while (first_en_cyc == -1 && n < bound) begin
      step();
      n++;
    end
    if (first_en_cyc == -1) begin
      errors++;
      checks++;
      $display("[TB] FAIL %s: no cnt_en within %0d cycles", name, bound);
    end
  endtask

  vec_t vecs[7];
  int   chg, frac, base, clr_base;

  initial begin
    reset              = 1'b1;
    sw_if.start_resume = 1'b0;
    sw_if.stop         = 1'b0;
    sw_if.lap          = 1'b0;
    sw_if.at_max       = 1'b0;

    for (int i = 0; i < 5; i++)
      vecs[i] = '{rst: 1'b1, start_resume: 1'b0, stop: 1'b0, lap: 1'b0, at_max: 1'b0,
                  exp_state: ST_IDLE, exp_en: 1'b0, exp_clr: 1'b1, exp_frz: 1'b0};
    vecs[5] = '{rst: 1'b0, start_resume: 1'b0, stop: 1'b0, lap: 1'b0, at_max: 1'b0,
                exp_state: ST_IDLE, exp_en: 1'b0, exp_clr: 1'b0, exp_frz: 1'b0};
    vecs[6] = '{rst: 1'b0, start_resume: 1'b0, stop: 1'b0, lap: 1'b0, at_max: 1'b1,
                exp_state: ST_IDLE, exp_en: 1'b0, exp_clr: 1'b0, exp_frz: 1'b0};

    $display("[TB] reset vectors");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end
    sw_if.at_max = 1'b0;

    $display("[TB] start and tick rate");
    first_en_cyc = -1;
    pressButton(3'b100, ST_IDLE, ST_RUN, "t2_start", chg);
    waitFirstEn("t2_first_en", 20);
    checkValue("t2_first_en_cycle", first_en_cyc, chg + TICK);
    base = en_count;
    repeat (100) step();
    checkValue("t2_pulses_in_100", en_count - base, 10);
    checkValue("t2_last_pulse_cycle", last_en_cyc, chg + 11 * TICK);

    $display("[TB] stop glitch, pause and resume");
    sw_if.stop = 1'b1;
    repeat (3) step();
    sw_if.stop = 1'b0;
    repeat (10) step();
    checkValue("t3_glitch_state", int'(sw_if.state), int'(ST_RUN));
    pressButton(3'b010, ST_RUN, ST_PAUSED, "t3_stop", chg);
    frac = chg - last_en_cyc;
    base = en_count;
    repeat (30) step();
    checkValue("t3_paused_silent", en_count - base, 0);
    first_en_cyc = -1;
    pressButton(3'b100, ST_PAUSED, ST_RUN, "t3_resume", chg);
    waitFirstEn("t3_resume_en", 20);
    checkValue("t3_resume_fraction", first_en_cyc, chg + TICK - frac);

    $display("[TB] lap view");
    pressButton(3'b001, ST_RUN, ST_LAP, "t4_lap_in", chg);
    checkValue("t4_freeze_on", int'(sw_if.disp_freeze), 1);
    base = en_count;
    repeat (20) step();
    checkValue("t4_lap_counting", en_count - base, 2);
    pressButton(3'b001, ST_LAP, ST_RUN, "t4_lap_out", chg);
    checkValue("t4_freeze_off", int'(sw_if.disp_freeze), 0);
    pressButton(3'b001, ST_RUN, ST_LAP, "t4_lap_again", chg);
    first_en_cyc = -1;
    waitFirstEn("t4_sync", 12);
    repeat (3) step();
    pressButton(3'b010, ST_LAP, ST_PAUSED, "t4_stop_lap", chg);
    checkValue("t4_stop_freeze", int'(sw_if.disp_freeze), 0);

    $display("[TB] stop+start together in PAUSED");
    clr_base = clr_count;
    pressButton(3'b110, ST_PAUSED, ST_IDLE, "t5_clear", chg);
    checkValue("t5_clr_pulses", clr_count - clr_base, 1);
    checkValue("t5_clr_low", int'(sw_if.cnt_clr), 0);
    pressButton(3'b001, ST_IDLE, ST_IDLE, "t5_lap_idle", chg);
    first_en_cyc = -1;
    pressButton(3'b100, ST_IDLE, ST_RUN, "t5_restart", chg);
    waitFirstEn("t5_first_en", 20);
    checkValue("t5_presc_cleared", first_en_cyc, chg + TICK);

    $display("[TB] at_max and reset mid-run");
    sw_if.at_max = 1'b1;
    base = en_count;
    repeat (TICK - 1) step();
    checkValue("t6_pre_tick_state", int'(sw_if.state), int'(ST_RUN));
    step();
    checkValue("t6_max_state", int'(sw_if.state), int'(ST_PAUSED));
    checkValue("t6_max_no_en", en_count - base, 0);
    checkValue("t6_max_freeze", int'(sw_if.disp_freeze), 0);
    sw_if.at_max = 1'b0;
    pressButton(3'b100, ST_PAUSED, ST_RUN, "t6_resume", chg);
    base = en_count;
    reset = 1'b1;
    step();
    checkValue("t6_rst_state", int'(sw_if.state), int'(ST_IDLE));
    checkValue("t6_rst_clr", int'(sw_if.cnt_clr), 1);
    checkValue("t6_rst_en", int'(sw_if.cnt_en), 0);
    reset = 1'b0;
    step();
    checkValue("t6_rel_clr", int'(sw_if.cnt_clr), 0);
    repeat (20) step();
    checkValue("t6_idle_silent", en_count - base, 0);
    checkValue("t6_idle_state", int'(sw_if.state), int'(ST_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
